// File: rtl/flap_pkg.sv
// Shared types and event encodings for the flap indicator and its button front end.
package flap_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounce_state_t;

  // Event codes consumed by the flap indicator.
  localparam logic [1:0] EVT_NONE     = 2'd0;
  localparam logic [1:0] EVT_POSITION = 2'd1;
  localparam logic [1:0] EVT_MODE     = 2'd2;

endpackage

// File: rtl/button_debouncer.sv
// One button channel: 2-FF synchroniser, polarity normalisation, debounce FSM,
// registered press pulse and debounced level.
//
// state        | meaning
// RELEASED     | accepted released, waiting for a press sample
// PRESS_WAIT   | press seen, counting consecutive pressed samples
// PRESSED      | accepted pressed, waiting for a release sample
// RELEASE_WAIT | release seen, counting consecutive released samples
import flap_pkg::*;

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic button,
  output logic press_re,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The edge that enters a WAIT state is already the first stable sample,
  // so acceptance happens when cnt has seen DEBOUNCE_CYCLES-1 more.
  localparam logic [CW-1:0] TC         = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic          IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic            sync_q1;
  logic            sync_q2;
  logic            p;
  debounce_state_t state;
  debounce_state_t state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            pulse_nxt;

  assign p = sync_q2 ^ IDLE_LEVEL;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync_q1  <= IDLE_LEVEL;
      sync_q2  <= IDLE_LEVEL;
      state    <= RELEASED;
      cnt      <= '0;
      press_re <= 1'b0;
    end else begin
      sync_q1  <= button;
      sync_q2  <= sync_q1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      press_re <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (p) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == TC) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == TC) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pressed   = (state == PRESSED) || (state == RELEASE_WAIT);
    pulse_nxt = (state == PRESS_WAIT) && p && (cnt == TC);
  end

endmodule

// File: rtl/flap_button_conditioner.sv
// Board button front end for the flap indicator: two independent debounced
// channels producing press pulses and debounced levels.
import flap_pkg::*;

module flap_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic button_position,
  input  logic button_mode,
  output logic change_position_re,
  output logic change_mode_re,
  output logic position_pressed,
  output logic mode_pressed
);

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_position (
    .clk       (clk),
    .sync_reset(sync_reset),
    .button    (button_position),
    .press_re  (change_position_re),
    .pressed   (position_pressed)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_mode (
    .clk       (clk),
    .sync_reset(sync_reset),
    .button    (button_mode),
    .press_re  (change_mode_re),
    .pressed   (mode_pressed)
  );

endmodule

// File: tb/tb_flap_button_conditioner.sv
// Bench for flap_button_conditioner: cycle model of the debounce rules plus
// directed scenarios with hand-computed pulse positions.
module tb_flap_button_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  logic button_position = 1'b1;
  logic button_mode = 1'b1;
  logic change_position_re;
  logic change_mode_re;
  logic position_pressed;
  logic mode_pressed;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  flap_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk               (clk),
    .sync_reset        (sync_reset),
    .button_position   (button_position),
    .button_mode       (button_mode),
    .change_position_re(change_position_re),
    .change_mode_re    (change_mode_re),
    .position_pressed  (position_pressed),
    .mode_pressed      (mode_pressed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a raw sample reaches the debouncer two edges later; the accepted
  // level flips once D consecutive samples disagree with it.
  logic dly0[2];
  logic dly1[2];
  logic lvl[2];
  logic pul[2];
  int   run[2];

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      logic raw_p;
      raw_p = (c == 0) ? ~button_position : ~button_mode;
      if (sync_reset) begin
        dly0[c] = 1'b0;
        dly1[c] = 1'b0;
        lvl[c]  = 1'b0;
        run[c]  = 0;
        pul[c]  = 1'b0;
      end else begin
        pul[c] = 1'b0;
        if (dly1[c] != lvl[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == D) begin
          lvl[c] = dly1[c];
          pul[c] = dly1[c];
          run[c] = 0;
        end
        dly1[c] = dly0[c];
        dly0[c] = raw_p;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model change_position_re", int'(change_position_re), int'(pul[0]));
      chk("model change_mode_re",     int'(change_mode_re),     int'(pul[1]));
      chk("model position_pressed",   int'(position_pressed),   int'(lvl[0]));
      chk("model mode_pressed",       int'(mode_pressed),       int'(lvl[1]));
    end
  end

  // Watch n cycles; report pulse counts, index (1-based) of last pulse, and
  // whether mode_pressed stayed high throughout.
  task automatic watch(input int n, output int pos_n, output int pos_at,
                       output int mode_n, output int mode_at, output int mode_lvl_all);
    pos_n = 0; pos_at = 0; mode_n = 0; mode_at = 0; mode_lvl_all = 1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (change_position_re) begin pos_n++; pos_at = i; end
      if (change_mode_re) begin mode_n++; mode_at = i; end
      if (!mode_pressed) mode_lvl_all = 0;
    end
  endtask

  initial begin
    int pn, pa, mn, ma, ml, acc;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset change_position_re", int'(change_position_re), 0);
    chk("reset change_mode_re",     int'(change_mode_re),     0);
    chk("reset position_pressed",   int'(position_pressed),   0);
    chk("reset mode_pressed",       int'(mode_pressed),       0);
    sync_reset = 1'b0;
    watch(5, pn, pa, mn, ma, ml);

    // clean position press
    button_position = 1'b0;
    watch(20, pn, pa, mn, ma, ml);
    chk("clean pos pulses", pn, 1);
    chk("clean pos pulse index", pa, 6);
    chk("clean mode pulses", mn, 0);
    chk("clean pos level", int'(position_pressed), 1);
    button_position = 1'b1;
    watch(12, pn, pa, mn, ma, ml);
    chk("release pos pulses", pn, 0);
    chk("release pos level", int'(position_pressed), 0);

    // mode bounce: 2-cycle low/high toggles, then stable low
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      button_mode = (k % 2 == 1);
      watch(2, pn, pa, mn, ma, ml);
      acc += mn;
    end
    chk("bounce mode pulses", acc, 0);
    chk("bounce mode level", int'(mode_pressed), 0);
    button_mode = 1'b0;
    watch(12, pn, pa, mn, ma, ml);
    chk("bounce final mode pulses", mn, 1);
    chk("bounce final mode index", ma, 6);
    chk("bounce final mode level", int'(mode_pressed), 1);

    // release glitch of 3 cycles
    button_mode = 1'b1;
    watch(3, pn, pa, mn, ma, ml);
    acc = ml;
    button_mode = 1'b0;
    watch(8, pn, pa, mn, ma, ml);
    chk("glitch mode level held", acc & ml, 1);
    chk("glitch mode pulses", mn, 0);
    button_mode = 1'b1;
    watch(8, pn, pa, mn, ma, ml);
    chk("stable release level", int'(mode_pressed), 0);
    chk("stable release pulses", mn, 0);

    // simultaneous press
    button_position = 1'b0;
    button_mode = 1'b0;
    watch(10, pn, pa, mn, ma, ml);
    chk("simul pos pulses", pn, 1);
    chk("simul mode pulses", mn, 1);
    chk("simul pos index", pa, 6);
    chk("simul mode index", ma, 6);
    button_position = 1'b1;
    button_mode = 1'b1;
    watch(12, pn, pa, mn, ma, ml);

    // reset mid-debounce, with mode already accepted pressed
    button_mode = 1'b0;
    watch(10, pn, pa, mn, ma, ml);
    chk("pre-reset mode pulses", mn, 1);
    button_position = 1'b0;
    watch(3, pn, pa, mn, ma, ml);
    sync_reset = 1'b1;
    button_position = 1'b1;
    button_mode = 1'b1;
    @(negedge clk);
    chk("midreset change_position_re", int'(change_position_re), 0);
    chk("midreset change_mode_re",     int'(change_mode_re),     0);
    chk("midreset position_pressed",   int'(position_pressed),   0);
    chk("midreset mode_pressed",       int'(mode_pressed),       0);
    sync_reset = 1'b0;
    watch(15, pn, pa, mn, ma, ml);
    chk("post-reset pos pulses", pn, 0);
    chk("post-reset mode pulses", mn, 0);

    // held through reset
    button_position = 1'b0;
    sync_reset = 1'b1;
    repeat (2) @(negedge clk);
    sync_reset = 1'b0;
    watch(8, pn, pa, mn, ma, ml);
    chk("held pos pulses", pn, 1);
    chk("held pos index", pa, 6);
    watch(20, pn, pa, mn, ma, ml);
    chk("held no repeat", pn, 0);
    chk("held pos level", int'(position_pressed), 1);
    button_position = 1'b1;
    watch(12, pn, pa, mn, ma, ml);
    chk("final pos level", int'(position_pressed), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
